mem_load_unit: RTL and testbench

- Read-side counterpart of the writeback/store path: accepts one load per transaction from EX, issues an aligned 64-bit read on the data-memory read port, then extracts, sign- or zero-extends and returns the result to WB as the memory-result operand.
- Sits between EX and WB.
- Single outstanding request; blocking, in-order.

---
 rtl/mem_load_unit_pkg.sv | 44 ++++
 rtl/mem_load_unit_extract.sv | 28 ++
 rtl/mem_load_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_load_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_load_unit_pkg.sv
// mem_load_unit_pkg: load-type encodings, FSM states and alignment helpers for mem_load_unit.
// The REQ2/WAIT2 states exist only when MEM_LOAD_SPLIT_EN is defined.
package mem_load_unit_pkg;

  typedef enum logic [2:0] {
    LT_LB      = 3'd0,
    LT_LH      = 3'd1,
    LT_LW      = 3'd2,
    LT_LD      = 3'd3,
    LT_LBU     = 3'd4,
    LT_LHU     = 3'd5,
    LT_LWU     = 3'd6,
    LT_ILLEGAL = 3'd7
  } lt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
`ifdef MEM_LOAD_SPLIT_EN
    ,
    ST_REQ2,
    ST_WAIT2
`endif
  } state_e;

  // Byte-offset bits cleared to form the 8-byte-aligned memory address.
  localparam logic [2:0] ALIGN_MASK = 3'b111;

  // Access size minus one; also the offset bits that must be zero for a natural alignment.
  function automatic logic [2:0] lt_size_mask(input logic [2:0] lt);
    logic [2:0] m;
    m = 3'b000;
    case (lt)
      LT_LH, LT_LHU: m = 3'b001;
      LT_LW, LT_LWU: m = 3'b011;
      LT_LD:         m = 3'b111;
      default:       m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_unit_extract.sv
// load_extract: selects the addressed lane of a 64-bit word and sign/zero-extends it by load type.
// Purely combinational so it can be shared with other read paths.
module load_extract
  import mem_load_unit_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  offset,
  input  logic [2:0]  ltype,
  output logic [63:0] result
);

  logic [63:0] lane;

  always_comb begin
    lane = data >> {offset, 3'b000};
    case (ltype)
      LT_LB:   result = {{56{lane[7]}}, lane[7:0]};
      LT_LBU:  result = {56'd0, lane[7:0]};
      LT_LH:   result = {{48{lane[15]}}, lane[15:0]};
      LT_LHU:  result = {48'd0, lane[15:0]};
      LT_LW:   result = {{32{lane[31]}}, lane[31:0]};
      LT_LWU:  result = {32'd0, lane[31:0]};
      LT_LD:   result = lane;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: single-outstanding blocking load path EX -> aligned 64-bit memory read -> WB.
// Define MEM_LOAD_SPLIT_EN to accept misaligned loads (two reads when a load crosses 8 bytes).
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [2:0]                in_ltype,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic [63:0]               out_data,
  output logic                      out_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state;
  lt_e         lt_q;
  logic [2:0]  off_q;
  logic [15:0] cnt;
  logic        reject;
  logic [63:0] ext_data;
  logic [63:0] ext_res;
  logic [2:0]  ext_off;

`ifdef MEM_LOAD_SPLIT_EN
  logic [63:0] lo_q;
  logic [3:0]  span;
  logic        cross;

  assign span   = {1'b0, off_q} + {1'b0, lt_size_mask(lt_q)};
  assign cross  = span[3];
  assign reject = (in_ltype == LT_ILLEGAL);

  // Second beat: pre-shift the {hi,lo} pair so the extractor works at offset 0.
  always_comb begin
    ext_data = mem_resp_data;
    ext_off  = off_q;
    if (state == ST_WAIT2) begin
      ext_data = 64'({mem_resp_data, lo_q} >> {off_q, 3'b000});
      ext_off  = 3'b000;
    end
  end
`else
  assign reject   = (in_ltype == LT_ILLEGAL) ||
                    ((in_addr[2:0] & lt_size_mask(in_ltype)) != 3'b000);
  assign ext_data = mem_resp_data;
  assign ext_off  = off_q;
`endif

  load_extract u_extract (
    .data   (ext_data),
    .offset (ext_off),
    .ltype  (lt_q),
    .result (ext_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      lt_q          <= LT_LB;
      off_q         <= '0;
      cnt           <= '0;
      in_ready      <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      out_valid     <= 1'b0;
      out_rd        <= '0;
      out_data      <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            lt_q     <= lt_e'(in_ltype);
            off_q    <= in_addr[2:0];
            out_rd   <= in_rd;
            in_ready <= 1'b0;
            if (reject) begin
              state     <= ST_RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_data  <= '0;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= in_addr & ~ADDR_W'(ALIGN_MASK);
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= ST_WAIT;
          end
        end
`ifdef MEM_LOAD_SPLIT_EN
        ST_REQ2: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= ST_WAIT2;
          end
        end
`endif
        ST_WAIT
`ifdef MEM_LOAD_SPLIT_EN
        , ST_WAIT2
`endif
        : begin
          cnt <= cnt + 16'd1;
          if (mem_resp_valid) begin
            state     <= ST_RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_data  <= ext_res;
`ifdef MEM_LOAD_SPLIT_EN
            // Crossing load: later assignments override the completion above and fetch the high word.
            if (state == ST_WAIT && cross) begin
              state         <= ST_REQ2;
              out_valid     <= 1'b0;
              lo_q          <= mem_resp_data;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= mem_req_addr + ADDR_W'(8);
            end
`endif
          end else if (cnt == TO_LAST) begin
            state     <= ST_RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_data  <= '0;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed and randomized loads against a byte-level reference model.
// Honours MEM_LOAD_SPLIT_EN the same way the design does.
module tb_mem_load_unit;

  localparam int TMO = 255;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [2:0]  in_ltype;
  logic [4:0]  in_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  mem_load_unit #(
    .ADDR_W         (64),
    .DATA_W         (64),
    .REG_ADDR_WIDTH (5),
    .TIMEOUT_CYC    (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_ltype       (in_ltype),
    .in_rd          (in_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rd         (out_rd),
    .out_data       (out_data),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: byte size/signedness per type, take bytes o..o+size-1 of the {hi,lo} little-endian pair.
  function automatic void model(input logic [63:0] addr, input logic [2:0] lt,
                                input logic [63:0] lo, input logic [63:0] hi,
                                output bit err, output logic [63:0] data, output int beats);
    int          o;
    int          sz;
    bit          sgn;
    logic [127:0] both;
    logic [63:0] lane;
    o    = int'(addr[2:0]);
    sz   = 0;
    sgn  = 1'b0;
    case (lt)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd2: begin sz = 4; sgn = 1'b1; end
      3'd3: begin sz = 8; sgn = 1'b0; end
      3'd4: begin sz = 1; sgn = 1'b0; end
      3'd5: begin sz = 2; sgn = 1'b0; end
      3'd6: begin sz = 4; sgn = 1'b0; end
      default: sz = 0;
    endcase
    both  = {hi, lo};
    lane  = 64'(both >> (8 * o));
    err   = 1'b0;
    data  = '0;
    beats = 1;
    if (sz == 0) begin
      err = 1'b1;
      beats = 0;
      return;
    end
    if ((o % sz) != 0) begin
`ifdef MEM_LOAD_SPLIT_EN
      beats = (o + sz > 8) ? 2 : 1;
`else
      err = 1'b1;
      beats = 0;
      return;
`endif
    end
    if (sz == 1) begin
      if (sgn) data = 64'($signed(lane[7:0]));
      else     data = 64'(lane[7:0]);
    end else if (sz == 2) begin
      if (sgn) data = 64'($signed(lane[15:0]));
      else     data = 64'(lane[15:0]);
    end else if (sz == 4) begin
      if (sgn) data = 64'($signed(lane[31:0]));
      else     data = 64'(lane[31:0]);
    end else begin
      data = lane;
    end
  endfunction

  // One full transaction: issue, act as memory, check result, latency and stability.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] lt,
                         input logic [4:0] rd, input logic [63:0] lo, input logic [63:0] hi,
                         input int req_stall, input int resp_dly, input int out_stall,
                         input bit no_resp);
    bit          e_err;
    logic [63:0] e_data;
    int          e_beats;
    int          e_lat;
    int          lat;
    int          w;
    bit          stable;
    bit          saw_req;
    logic [63:0] h_addr;
    logic [63:0] h_data;
    logic        h_err;
    logic [4:0]  h_rd;

    model(addr, lt, lo, hi, e_err, e_data, e_beats);
    e_lat = 1 + e_beats * (2 + req_stall + resp_dly);
    if (no_resp) begin
      e_err  = 1'b1;
      e_data = '0;
      e_lat  = 1 + req_stall + 1 + TMO;
    end

    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_addr  = addr;
    in_ltype = lt;
    in_rd    = rd;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = {$urandom, $urandom};
    in_ltype = 3'($urandom);
    in_rd    = 5'($urandom);
    lat      = 1;
    saw_req  = 1'b0;

    for (int b = 0; b < e_beats; b++) begin
      w = 0;
      while (!mem_req_valid && w < 16) begin
        @(negedge clk);
        lat++;
        w++;
      end
      check({tag, ".req_addr"}, mem_req_addr, (addr & ~64'h7) + 64'(8 * b));
      if (req_stall > 0) begin
        stable = 1'b1;
        h_addr = mem_req_addr;
        for (int s = 0; s < req_stall; s++) begin
          @(negedge clk);
          lat++;
          if (mem_req_valid !== 1'b1 || mem_req_addr !== h_addr || in_ready !== 1'b0) stable = 1'b0;
        end
        check({tag, ".req_stable"}, 64'(stable), 64'd1);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      lat++;
      mem_req_ready = 1'b0;
      for (int d = 0; d < resp_dly; d++) begin
        @(negedge clk);
        lat++;
      end
      if (!no_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = (b == 0) ? lo : hi;
        @(negedge clk);
        lat++;
        mem_resp_valid = 1'b0;
        mem_resp_data  = {$urandom, $urandom};
      end
    end

    w = 0;
    while (!out_valid && w < 600) begin
      if (mem_req_valid) saw_req = 1'b1;
      @(negedge clk);
      lat++;
      w++;
    end
    if (mem_req_valid) saw_req = 1'b1;
    if (e_beats == 0) check({tag, ".no_req"}, 64'(saw_req), 64'd0);
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(e_lat));
    check({tag, ".out_err"}, 64'(out_err), 64'(e_err));
    check({tag, ".out_data"}, out_data, e_data);
    check({tag, ".out_rd"}, 64'(out_rd), 64'(rd));

    if (out_stall > 0) begin
      stable = 1'b1;
      h_data = out_data;
      h_err  = out_err;
      h_rd   = out_rd;
      for (int s = 0; s < out_stall; s++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== h_data || out_err !== h_err ||
            out_rd !== h_rd || in_ready !== 1'b0) stable = 1'b0;
      end
      check({tag, ".out_stable"}, 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".released"}, 64'({out_valid, in_ready}), 64'd1);
  endtask

  initial begin
    logic [63:0] r_addr;
    logic [63:0] r_lo;
    logic [63:0] r_hi;
    logic [2:0]  r_lt;

    rst            = 1'b1;
    in_valid       = 1'b0;
    in_addr        = '0;
    in_ltype       = '0;
    in_rd          = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    out_ready      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.req", {63'd0, mem_req_valid} | mem_req_addr, 64'd0);
    check("reset.out", {58'd0, out_valid, out_err, out_rd} | out_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_load("lb", 64'h8000_0003, 3'd0, 5'd1, 64'h1122_3344_8566_7788, 64'h0, 0, 0, 0, 1'b0);
    do_load("lwu", 64'h8000_0004, 3'd6, 5'd2, 64'h1122_3344_8566_7788, 64'h0, 0, 0, 0, 1'b0);
    do_load("lw_neg", 64'h8000_0004, 3'd2, 5'd0, 64'h8000_0001_1234_5678, 64'h0, 0, 0, 0, 1'b0);
    do_load("ld", 64'h8000_0008, 3'd3, 5'd31, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 0, 0, 1'b0);
    do_load("lhu_hi", 64'h8000_0006, 3'd5, 5'd3, 64'hF00D_0000_0000_0000, 64'h0, 0, 0, 0, 1'b0);
    do_load("illegal", 64'h8000_0000, 3'd7, 5'd4, 64'h0, 64'h0, 0, 0, 0, 1'b0);
`ifdef MEM_LOAD_SPLIT_EN
    do_load("ld_split", 64'h8000_0006, 3'd3, 5'd5, 64'hAABB_0000_0000_0000,
            64'h0000_0000_0000_CCDD, 0, 0, 0, 1'b0);
    do_load("lw_split", 64'h8000_0007, 3'd2, 5'd6, 64'h8800_0000_0000_0000,
            64'h0000_0000_00AA_BBCC, 1, 2, 1, 1'b0);
`else
    do_load("lw_misalign", 64'h8000_0002, 3'd2, 5'd5, 64'h1, 64'h0, 0, 0, 0, 1'b0);
    do_load("lh_misalign", 64'h8000_0001, 3'd1, 5'd6, 64'h1, 64'h0, 0, 0, 0, 1'b0);
`endif
    do_load("stalls", 64'h8000_0010, 3'd3, 5'd9, 64'h0123_4567_89AB_CDEF, 64'h0, 5, 0, 4, 1'b0);
    do_load("resp_last", 64'h8000_0020, 3'd2, 5'd10, 64'h0000_0000_F000_0001, 64'h0,
            0, TMO - 1, 0, 1'b0);
    do_load("timeout", 64'h8000_0018, 3'd3, 5'd11, 64'h0, 64'h0, 0, 0, 0, 1'b1);

    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("late_resp.idle", {62'd0, out_valid, in_ready}, 64'd1);
    do_load("after_timeout", 64'h8000_0001, 3'd4, 5'd12, 64'h0000_0000_0000_9900, 64'h0,
            0, 1, 0, 1'b0);

    // Reset while waiting for the memory response.
    in_valid = 1'b1;
    in_addr  = 64'h8000_0040;
    in_ltype = 3'd3;
    in_rd    = 5'd5;
    @(negedge clk);
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait.in_ready", 64'(in_ready), 64'd1);
    check("rst_wait.req", {63'd0, mem_req_valid} | mem_req_addr, 64'd0);
    check("rst_wait.out", {58'd0, out_valid, out_err, out_rd} | out_data, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h1234;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("rst_wait.late_resp", {62'd0, out_valid, in_ready}, 64'd1);

    for (int i = 0; i < 60; i++) begin
      r_lt   = 3'($urandom_range(0, 7));
      r_addr = {$urandom, $urandom};
      r_addr[2:0] = $urandom_range(0, 1) ? 3'($urandom) : 3'b000;
      r_lo   = {$urandom, $urandom};
      r_hi   = {$urandom, $urandom};
      do_load($sformatf("rand%0d", i), r_addr, r_lt, 5'($urandom), r_lo, r_hi,
              $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
